nibble_serial_adder: RTL and testbench

//  Wide adder built as a sequencer around one 4-bit ripple-carry slice. Latches

---
 rtl/nibble_serial_adder_pkg.sv | 22 ++
 rtl/nibble_serial_adder_if.sv | 45 ++++
 rtl/nibble_serial_adder_rca4_slice.sv | 37 +++
 rtl/nibble_serial_adder.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_pkg
// Description : Shared constants for the nibble-serial adder: slice width
//               and FSM state encodings (IDLE / RUN / DONE).
// Config      : none (the NSA_OVERFLOW_EN macro is consumed by the interface
//               and top, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_add_pkg;

    // Width of the single ripple-carry slice the sequencer drives.
    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage : nibble_add_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_if
// Description : Request / result bundle of the nibble-serial adder.
//               master : start, a, b, cin out; busy, done, sum, cout (ovf) in
//               slave  : mirror image, used by the adder itself
// Config      : NSA_OVERFLOW_EN adds the ovf signal to both modports
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NSA_OVERFLOW_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface : nibble_serial_adder_if
`default_nettype wire

// File: rtl/nibble_serial_adder_rca4_slice.sv
`default_nettype none
// ============================================================================
// Module      : rca4_slice
// Description : Combinational 4-bit ripple-carry adder slice.
//               a, b, cin -> sum, cout; c3 is the carry into bit 3, which the
//               sequencer uses to form signed overflow on the MSB nibble.
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module rca4_slice
    import nibble_add_pkg::*;
(
    input  wire logic [NIBBLE_W-1:0] a,
    input  wire logic [NIBBLE_W-1:0] b,
    input  wire logic                cin,
    output logic      [NIBBLE_W-1:0] sum,
    output logic                     cout,
    output logic                     c3
);

    // Carry chain kept local to a single process so it ripples bit by bit.
    logic [NIBBLE_W:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
        cout = w_c[NIBBLE_W];
        c3   = w_c[NIBBLE_W-1];
    end

endmodule : rca4_slice
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder that latches operands on start and feeds one
//               4-bit ripple-carry slice a nibble per cycle, LSB first.
//               clk, rst    : clock, synchronous active-high reset
//               bus (slave) : start/a/b/cin request, busy/done/sum/cout result
//               (plus ovf when NSA_OVERFLOW_EN is defined)
// Config      : NSA_OVERFLOW_EN - adds the signed-overflow output
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    nibble_serial_adder_if.slave bus
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_slice_cout;
    logic                w_slice_c3;

    assign w_a_nib = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = b_q[idx_q * NIBBLE_W +: NIBBLE_W];

    rca4_slice u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (carry_q),
        .sum  (w_sum_nib),
        .cout (w_slice_cout),
        .c3   (w_slice_c3)
    );

    // ------------------------------------------------------------------
    // State register (rst has priority, so a coincident start is dropped)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q * NIBBLE_W +: NIBBLE_W] = w_sum_nib;
                carry_d = w_slice_cout;
                if (idx_q == LAST_IDX) begin
                    // idx stays at the last nibble; it is cleared on next start.
                    cout_d  = w_slice_cout;
                    ovf_d   = w_slice_c3 ^ w_slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
`ifdef NSA_OVERFLOW_EN
        bus.ovf  = ovf_q;
`endif
    end

`ifndef NSA_OVERFLOW_EN
    // Overflow is only exported when the feature is built in.
    logic w_ovf_unused;
    assign w_ovf_unused = ovf_q;
`endif

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Directed and random self-checking bench for the
//               nibble-serial adder (WIDTH=16, four nibbles per add).
// Config      : NSA_OVERFLOW_EN - also exercises the ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one add from IDLE and wait (bounded) for done; returns one cycle
    // later so the adder is back in IDLE for the next request.
    task automatic do_add(input logic [15:0] a, input logic [15:0] b,
                          input logic cin,
                          output logic [15:0] s, output logic co,
                          output logic ov, output int lat, output bit tmo);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        tick();
        bus.start = 1'b0;
        lat = 0;
        tmo = 1'b1;
        s   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = i;
                tmo = 1'b0;
                s   = bus.sum;
                co  = bus.cout;
`ifdef NSA_OVERFLOW_EN
                ov  = bus.ovf;
`endif
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.cin   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy=%b done=%b sum=%h cout=%b, required 0 0 0000 0",
                         i, bus.busy, bus.done, bus.sum, bus.cout);
            end
`ifdef NSA_OVERFLOW_EN
            n_checks++;
            if (bus.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ovf[%0d]: ovf=%b, required 0", i, bus.ovf);
            end
`endif
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy=%b, required 0", bus.busy);
        end
    endtask

    // FFFF+0001: full carry ripple, operands scrambled after acceptance.
    task automatic test_wrap();
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0001;
        bus.cin   = 1'b0;
        tick();                         // edge k
        bus.start = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        bus.cin   = 1'b1;
        for (int j = 0; j <= 3; j++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_busy[k+%0d]: busy=%b done=%b, required 1 0",
                         j, bus.busy, bus.done);
            end
            tick();
        end
        // now after edge k+4
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: busy=%b done=%b, required 0 1", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_result: sum=%h cout=%b, required 0000 1", bus.sum, bus.cout);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_hold: done=%b sum=%h cout=%b, required 0 0000 1",
                     bus.done, bus.sum, bus.cout);
        end
    endtask

    // start held high through RUN/DONE: one done, re-accept at edge k+6.
    task automatic test_start_held();
        int dones;
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h4321;
        bus.cin   = 1'b1;
        tick();                         // edge k
        dones = 0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (bus.done === 1'b1) dones++;
            if (j == 4) begin
                n_checks++;
                if (bus.sum !== 16'h5556 || bus.cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_result: sum=%h cout=%b, required 5556 0",
                             bus.sum, bus.cout);
                end
            end
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL held_done_count: got %0d pulses, required 1", dones);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle_k5: busy=%b, required 0", bus.busy);
        end
        tick();                         // edge k+6: accepted again
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reaccept_k6: busy=%b, required 1", bus.busy);
        end
        for (int j = 0; j < N + 2; j++) tick();
    endtask

    // rst while idx=2 aborts with no done pulse; then a clean add.
    task automatic test_abort();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          tmo;
        int          dones;
        bus.start = 1'b1;
        bus.a     = 16'h00FF;
        bus.b     = 16'h0F0F;
        bus.cin   = 1'b0;
        tick();                         // edge k
        bus.start = 1'b0;
        tick();                         // k+1
        tick();                         // k+2, idx=2
        rst = 1'b1;
        tick();                         // k+3
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.cout} !== 3'b000 || bus.sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b, required 0 0 0000 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        dones = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles, required 0", dones);
        end
        do_add(16'h0001, 16'h0001, 1'b0, s, co, ov, lat, tmo);
        n_checks++;
        if (tmo || s !== 16'h0002 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: timeout=%0d sum=%h cout=%b, required 0 0002 0",
                     tmo, s, co);
        end
        n_checks++;
        if (lat !== N) begin
            n_fail++;
            $display("FAIL abort_latency: %0d cycles, required %0d", lat, N);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, s;
        logic        cin, co, ov;
        logic [16:0] exp_full;
        logic        exp_ovf;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 1000; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            exp_full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            exp_ovf  = (a[15] == b[15]) && (exp_full[15] != a[15]);
            do_add(a, b, cin, s, co, ov, lat, tmo);
            n_checks++;
            if (tmo || {co, s} !== exp_full || lat !== N) begin
                n_fail++;
                $display("FAIL rand[%0d] %h+%h+%b: timeout=%0d lat=%0d got %h, required %h",
                         i, a, b, cin, tmo, lat, {co, s}, exp_full);
            end
`ifdef NSA_OVERFLOW_EN
            n_checks++;
            if (ov !== exp_ovf) begin
                n_fail++;
                $display("FAIL rand_ovf[%0d] %h+%h+%b: ovf=%b, required %b",
                         i, a, b, cin, ov, exp_ovf);
            end
`else
            if (ov !== 1'b0 && exp_ovf) begin end
`endif
        end
    endtask

`ifdef NSA_OVERFLOW_EN
    task automatic test_overflow();
        logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h1234};
        logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h4321};
        logic [15:0] vs [3] = '{16'h8000, 16'h7FFF, 16'h5555};
        logic        vc [3] = '{1'b0, 1'b1, 1'b0};
        logic        vo [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 3; i++) begin
            do_add(va[i], vb[i], 1'b0, s, co, ov, lat, tmo);
            n_checks++;
            if (tmo || s !== vs[i] || co !== vc[i] || ov !== vo[i]) begin
                n_fail++;
                $display("FAIL ovf[%0d] %h+%h: timeout=%0d sum=%h cout=%b ovf=%b, required %h %b %b",
                         i, va[i], vb[i], tmo, s, co, ov, vs[i], vc[i], vo[i]);
            end
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_wrap();
        test_start_held();
        test_abort();
`ifdef NSA_OVERFLOW_EN
        test_overflow();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_adder
`default_nettype wire
